// File: rtl/cordic_angle_sequencer_if.sv
// Request/response and CORDIC-side handshake bundle for cordic_angle_sequencer.
// master drives requests and CORDIC status; slave is the sequencer itself.
interface cordic_angle_sequencer_if #(
  parameter int W = 16
);
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_angle;
  logic         req_op;
  logic         beg_FSM_CORDIC;
  logic         operation;
  logic [1:0]   shift_region_flag;
  logic [W-1:0] angle_out;
  logic         ready_CORDIC;
  logic [W-1:0] cordic_result;
  logic         ACK_FSM_CORDIC;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;
  logic         rsp_error;

  modport master (
    output req_valid, req_angle, req_op, ready_CORDIC, cordic_result, rsp_ready,
    input  req_ready, beg_FSM_CORDIC, operation, shift_region_flag, angle_out,
           ACK_FSM_CORDIC, rsp_valid, rsp_data, rsp_error
  );

  modport slave (
    input  req_valid, req_angle, req_op, ready_CORDIC, cordic_result, rsp_ready,
    output req_ready, beg_FSM_CORDIC, operation, shift_region_flag, angle_out,
           ACK_FSM_CORDIC, rsp_valid, rsp_data, rsp_error
  );
endinterface

// File: rtl/cordic_angle_sequencer.sv
// Accepts one angle request, range-reduces it by quadrant, starts the CORDIC
// FSM, waits (with timeout) for its result and returns it as a response.
module cordic_angle_sequencer #(
  parameter int W       = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  cordic_angle_sequencer_if.slave   bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, START, WAIT, ACK, RESP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    quad;

  assign quad = bus.req_angle[W-1:W-2];

  always_ff @(posedge clk) begin
    if (reset) begin
      state                 <= IDLE;
      cnt                   <= '0;
      bus.req_ready         <= 1'b1;
      bus.beg_FSM_CORDIC    <= 1'b0;
      bus.operation         <= 1'b0;
      bus.shift_region_flag <= 2'b00;
      bus.angle_out         <= '0;
      bus.ACK_FSM_CORDIC    <= 1'b0;
      bus.rsp_valid         <= 1'b0;
      bus.rsp_data          <= '0;
      bus.rsp_error         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            bus.operation         <= bus.req_op;
            bus.shift_region_flag <= quad;
            // Fourth quadrant maps to a negative angle (angle - 2*pi).
            bus.angle_out         <= {(quad == 2'b11) ? 2'b11 : 2'b00, bus.req_angle[W-3:0]};
            bus.req_ready         <= 1'b0;
            bus.beg_FSM_CORDIC    <= 1'b1;
            state                 <= START;
          end
        end
        START: begin
          bus.beg_FSM_CORDIC <= 1'b0;
          cnt                <= '0;
          state              <= WAIT;
        end
        WAIT: begin
          if (bus.ready_CORDIC) begin
            bus.rsp_data       <= bus.cordic_result;
            bus.rsp_error      <= 1'b0;
            bus.ACK_FSM_CORDIC <= 1'b1;
            state              <= ACK;
          end else if (cnt == LAST) begin
            bus.rsp_data  <= '0;
            bus.rsp_error <= 1'b1;
            bus.rsp_valid <= 1'b1;
            state         <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ACK: begin
          bus.ACK_FSM_CORDIC <= 1'b0;
          bus.rsp_valid      <= 1'b1;
          state              <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          state              <= IDLE;
          bus.req_ready      <= 1'b1;
          bus.beg_FSM_CORDIC <= 1'b0;
          bus.ACK_FSM_CORDIC <= 1'b0;
          bus.rsp_valid      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cordic_angle_sequencer.sv
// Directed bench for cordic_angle_sequencer (W=16, TIMEOUT=8).
module tb_cordic_angle_sequencer;
  localparam int W  = 16;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  cordic_angle_sequencer_if #(.W(W)) bus ();

  cordic_angle_sequencer #(.W(W), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reset with a request held: idle outputs, then accept on the first edge after release.
  task automatic test_reset();
    reset = 1'b1;
    bus.req_valid = 1'b1; bus.req_angle = 16'h6000; bus.req_op = 1'b1;
    bus.ready_CORDIC = 1'b0; bus.cordic_result = '0; bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL rst_req_ready: got %b want 1", bus.req_ready); end
    n_cmp++; if (bus.beg_FSM_CORDIC !== 1'b0) begin n_err++; $display("FAIL rst_beg: got %b want 0", bus.beg_FSM_CORDIC); end
    n_cmp++; if (bus.operation !== 1'b0) begin n_err++; $display("FAIL rst_operation: got %b want 0", bus.operation); end
    n_cmp++; if (bus.shift_region_flag !== 2'b00) begin n_err++; $display("FAIL rst_flag: got %b want 00", bus.shift_region_flag); end
    n_cmp++; if (bus.angle_out !== 16'h0000) begin n_err++; $display("FAIL rst_angle: got %h want 0000", bus.angle_out); end
    n_cmp++; if (bus.ACK_FSM_CORDIC !== 1'b0) begin n_err++; $display("FAIL rst_ack: got %b want 0", bus.ACK_FSM_CORDIC); end
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid: got %b want 0", bus.rsp_valid); end
    n_cmp++; if (bus.rsp_data !== 16'h0000) begin n_err++; $display("FAIL rst_rsp_data: got %h want 0000", bus.rsp_data); end
    n_cmp++; if (bus.rsp_error !== 1'b0) begin n_err++; $display("FAIL rst_rsp_error: got %b want 0", bus.rsp_error); end
    reset = 1'b0;
  endtask

  // Request 0x6000/sine accepted at release edge; result at the 4th WAIT edge.
  task automatic test_basic();
    @(negedge clk);
    bus.req_valid = 1'b0; bus.req_angle = 16'hFFFF; bus.req_op = 1'b0;
    n_cmp++; if (bus.beg_FSM_CORDIC !== 1'b1) begin n_err++; $display("FAIL basic_beg_hi: got %b want 1", bus.beg_FSM_CORDIC); end
    n_cmp++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL basic_req_ready: got %b want 0", bus.req_ready); end
    n_cmp++; if (bus.shift_region_flag !== 2'b01) begin n_err++; $display("FAIL basic_flag: got %b want 01", bus.shift_region_flag); end
    n_cmp++; if (bus.angle_out !== 16'h2000) begin n_err++; $display("FAIL basic_angle: got %h want 2000", bus.angle_out); end
    n_cmp++; if (bus.operation !== 1'b1) begin n_err++; $display("FAIL basic_op: got %b want 1", bus.operation); end
    @(negedge clk);
    n_cmp++; if (bus.beg_FSM_CORDIC !== 1'b0) begin n_err++; $display("FAIL basic_beg_lo: got %b want 0", bus.beg_FSM_CORDIC); end
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.ACK_FSM_CORDIC !== 1'b0) begin n_err++; $display("FAIL basic_ack_early: got %b want 0", bus.ACK_FSM_CORDIC); end
    bus.ready_CORDIC = 1'b1; bus.cordic_result = 16'h5A82;
    @(negedge clk);
    bus.ready_CORDIC = 1'b0; bus.cordic_result = 16'h0000;
    n_cmp++; if (bus.ACK_FSM_CORDIC !== 1'b1) begin n_err++; $display("FAIL basic_ack_hi: got %b want 1", bus.ACK_FSM_CORDIC); end
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_early: got %b want 0", bus.rsp_valid); end
    @(negedge clk);
    n_cmp++; if (bus.ACK_FSM_CORDIC !== 1'b0) begin n_err++; $display("FAIL basic_ack_lo: got %b want 0", bus.ACK_FSM_CORDIC); end
    n_cmp++; if (bus.rsp_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b want 1", bus.rsp_valid); end
    n_cmp++; if (bus.rsp_data !== 16'h5A82) begin n_err++; $display("FAIL basic_data: got %h want 5a82", bus.rsp_data); end
    n_cmp++; if (bus.rsp_error !== 1'b0) begin n_err++; $display("FAIL basic_error: got %b want 0", bus.rsp_error); end
    n_cmp++; if (bus.angle_out !== 16'h2000) begin n_err++; $display("FAIL basic_angle_held: got %h want 2000", bus.angle_out); end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_drop: got %b want 0", bus.rsp_valid); end
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL basic_idle: got %b want 1", bus.req_ready); end
  endtask

  // Quadrants 3 and 2, each with ready at the first WAIT edge (minimum latency).
  task automatic test_quadrants();
    logic [15:0] angles [2];
    logic [1:0]  flags  [2];
    logic [15:0] reduced[2];
    logic [15:0] results[2];
    angles = '{16'hE000, 16'h9000};
    flags  = '{2'b11, 2'b10};
    reduced = '{16'hE000, 16'h1000};
    results = '{16'hBEEF, 16'h1111};
    for (int i = 0; i < 2; i++) begin
      bus.req_valid = 1'b1; bus.req_angle = angles[i]; bus.req_op = i[0];
      @(negedge clk);
      bus.req_valid = 1'b0; bus.req_angle = 16'h0000;
      n_cmp++; if (bus.beg_FSM_CORDIC !== 1'b1) begin n_err++; $display("FAIL quad%0d_beg: got %b want 1", i, bus.beg_FSM_CORDIC); end
      n_cmp++; if (bus.shift_region_flag !== flags[i]) begin n_err++; $display("FAIL quad%0d_flag: got %b want %b", i, bus.shift_region_flag, flags[i]); end
      n_cmp++; if (bus.angle_out !== reduced[i]) begin n_err++; $display("FAIL quad%0d_angle: got %h want %h", i, bus.angle_out, reduced[i]); end
      n_cmp++; if (bus.operation !== i[0]) begin n_err++; $display("FAIL quad%0d_op: got %b want %b", i, bus.operation, i[0]); end
      @(negedge clk);
      bus.ready_CORDIC = 1'b1; bus.cordic_result = results[i];
      @(negedge clk);
      bus.ready_CORDIC = 1'b0;
      n_cmp++; if (bus.ACK_FSM_CORDIC !== 1'b1) begin n_err++; $display("FAIL quad%0d_ack: got %b want 1", i, bus.ACK_FSM_CORDIC); end
      @(negedge clk);
      n_cmp++; if (bus.rsp_valid !== 1'b1) begin n_err++; $display("FAIL quad%0d_valid: got %b want 1", i, bus.rsp_valid); end
      n_cmp++; if (bus.rsp_data !== results[i]) begin n_err++; $display("FAIL quad%0d_data: got %h want %h", i, bus.rsp_data, results[i]); end
      n_cmp++; if (bus.angle_out !== reduced[i]) begin n_err++; $display("FAIL quad%0d_angle_held: got %h want %h", i, bus.angle_out, reduced[i]); end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
    end
  endtask

  // No ready for 8 WAIT edges: error response, no ACK.
  task automatic test_timeout();
    bus.req_valid = 1'b1; bus.req_angle = 16'h1234; bus.req_op = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    n_cmp++; if (bus.angle_out !== 16'h1234) begin n_err++; $display("FAIL to_angle: got %h want 1234", bus.angle_out); end
    @(negedge clk);
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      n_cmp++; if (bus.rsp_valid !== (k == TO)) begin n_err++; $display("FAIL to_valid_k%0d: got %b want %b", k, bus.rsp_valid, (k == TO)); end
      n_cmp++; if (bus.ACK_FSM_CORDIC !== 1'b0) begin n_err++; $display("FAIL to_ack_k%0d: got %b want 0", k, bus.ACK_FSM_CORDIC); end
    end
    n_cmp++; if (bus.rsp_error !== 1'b1) begin n_err++; $display("FAIL to_error: got %b want 1", bus.rsp_error); end
    n_cmp++; if (bus.rsp_data !== 16'h0000) begin n_err++; $display("FAIL to_data: got %h want 0000", bus.rsp_data); end
  endtask

  // Held error response under backpressure; new requests ignored until one idle bubble.
  task automatic test_backpressure();
    bus.req_valid = 1'b1; bus.req_angle = 16'h4000; bus.req_op = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_error !== 1'b1 || bus.rsp_data !== 16'h0000)
        begin n_err++; $display("FAIL bp_hold_k%0d: got v=%b e=%b d=%h want v=1 e=1 d=0000", k, bus.rsp_valid, bus.rsp_error, bus.rsp_data); end
      n_cmp++; if (bus.req_ready !== 1'b0 || bus.beg_FSM_CORDIC !== 1'b0)
        begin n_err++; $display("FAIL bp_noaccept_k%0d: got rdy=%b beg=%b want 0 0", k, bus.req_ready, bus.beg_FSM_CORDIC); end
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0; bus.req_valid = 1'b0;
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL bp_release: got %b want 0", bus.rsp_valid); end
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL bp_idle: got %b want 1", bus.req_ready); end
    n_cmp++; if (bus.beg_FSM_CORDIC !== 1'b0) begin n_err++; $display("FAIL bp_bubble_beg: got %b want 0", bus.beg_FSM_CORDIC); end
    @(negedge clk);
    n_cmp++; if (bus.shift_region_flag !== 2'b00) begin n_err++; $display("FAIL bp_flag_kept: got %b want 00", bus.shift_region_flag); end
  endtask

  // Reset in WAIT aborts; a late ready in IDLE does nothing.
  task automatic test_reset_mid();
    bus.req_valid = 1'b1; bus.req_angle = 16'h6000; bus.req_op = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL rm_req_ready: got %b want 1", bus.req_ready); end
    n_cmp++; if (bus.shift_region_flag !== 2'b00 || bus.angle_out !== 16'h0000 || bus.operation !== 1'b0)
      begin n_err++; $display("FAIL rm_cleared: got f=%b a=%h op=%b want 00 0000 0", bus.shift_region_flag, bus.angle_out, bus.operation); end
    bus.ready_CORDIC = 1'b1; bus.cordic_result = 16'h7777;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_cmp++; if (bus.ACK_FSM_CORDIC !== 1'b0 || bus.rsp_valid !== 1'b0)
        begin n_err++; $display("FAIL rm_late_ready_k%0d: got ack=%b v=%b want 0 0", k, bus.ACK_FSM_CORDIC, bus.rsp_valid); end
      n_cmp++; if (bus.rsp_data !== 16'h0000) begin n_err++; $display("FAIL rm_data_k%0d: got %h want 0000", k, bus.rsp_data); end
    end
    bus.ready_CORDIC = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_quadrants();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish before 100000");
    $fatal(1);
  end
endmodule
